// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: play/pause FSM, saturating 2-digit BCD score and ball reserve.
// Drives the countdown timer reload and the motion-freeze and text-overlay selects.
module pong_game_ctrl #(
  parameter int unsigned BALLS  = 3,
  parameter int unsigned BALL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        btn,
  input  logic              hit,
  input  logic              miss,
  input  logic              timer_up,
  output logic              timer_start,
  output logic              gra_still,
  output logic              show_rule,
  output logic              show_over,
  output logic [3:0]        score_d1,
  output logic [3:0]        score_d0,
  output logic [BALL_W-1:0] balls_left
);

  localparam logic [BALL_W-1:0] BallsInit  = BALL_W'(BALLS);
  localparam logic [BALL_W-1:0] BallsStart = BALL_W'(BALLS - 1);

  typedef enum logic [1:0] {
    StNewGame = 2'b00,
    StPlay    = 2'b01,
    StNewBall = 2'b10,
    StOver    = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        d1_q, d1_d;
  logic [3:0]        d0_q, d0_d;
  logic [BALL_W-1:0] balls_q, balls_d;
  logic              start_raw;
  logic              btn_pressed;
  logic              score_sat;

  assign btn_pressed = |btn;
  assign score_sat   = (d1_q == 4'd9) && (d0_q == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StNewGame;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
      balls_q <= BallsInit;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      balls_q <= balls_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    balls_d   = balls_q;
    start_raw = 1'b0;
    gra_still = 1'b1;
    show_rule = 1'b0;
    show_over = 1'b0;

    case (state_q)
      StNewGame: begin
        show_rule = 1'b1;
        if (btn_pressed) begin
          state_d = StPlay;
          balls_d = BallsStart;
        end
      end

      StPlay: begin
        gra_still = 1'b0;
        if (hit && !score_sat) begin
          if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            d1_d = d1_q + 4'd1;
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
        // A miss in the same cycle as a hit still ends the rally.
        if (miss) begin
          start_raw = 1'b1;
          if (balls_q != '0) begin
            state_d = StNewBall;
            balls_d = balls_q - BALL_W'(1);
          end else begin
            state_d = StOver;
          end
        end
      end

      StNewBall: begin
        if (timer_up && btn_pressed) begin
          state_d = StPlay;
        end
      end

      StOver: begin
        show_over = 1'b1;
        if (timer_up) begin
          state_d = StNewGame;
          d1_d    = 4'd0;
          d0_d    = 4'd0;
          balls_d = BallsInit;
        end
      end

      default: begin
        state_d = StNewGame;
      end
    endcase
  end

  // Reload pulse is suppressed while reset is held so the timer never starts spuriously.
  assign timer_start = start_raw & ~reset;
  assign score_d1    = d1_q;
  assign score_d0    = d0_q;
  assign balls_left  = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: hand-computed expectations for each play scenario.
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       timer_up;
  logic       timer_start;
  logic       gra_still;
  logic       show_rule;
  logic       show_over;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;

  int n_checks;
  int n_pass;

  // Overlay flag triples {gra_still, show_rule, show_over}
  localparam int FlNewGame = 3'b110;
  localparam int FlPlay    = 3'b000;
  localparam int FlNewBall = 3'b100;
  localparam int FlOver    = 3'b101;

  pong_game_ctrl #(
    .BALLS (3),
    .BALL_W(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .timer_up   (timer_up),
    .timer_start(timer_start),
    .gra_still  (gra_still),
    .show_rule  (show_rule),
    .show_over  (show_over),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare the visible state.
  task automatic expect_state(input string tag, input int flags, input int score,
                              input int balls);
    #1;
    check({tag, ".flags"}, {gra_still, show_rule, show_over}, flags);
    check({tag, ".score"}, {score_d1, score_d0}, score);
    check({tag, ".balls"}, balls_left, balls);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      tick();
    end
    hit = 1'b0;
  endtask

  // Miss in PLAY: timer_start must pulse in this cycle only.
  task automatic do_miss(input string tag);
    miss = 1'b1;
    #1;
    check({tag, ".ts_miss"}, timer_start, 1);
    tick();
    miss = 1'b0;
    #1;
    check({tag, ".ts_after"}, timer_start, 0);
  endtask

  task automatic relaunch();
    btn      = 2'b10;
    timer_up = 1'b1;
    tick();
    btn      = 2'b00;
    timer_up = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    btn      = 2'b00;
    hit      = 1'b0;
    miss     = 1'b0;
    timer_up = 1'b0;
    tick();
    reset = 1'b0;

    // 1: idle in NEWGAME; stray hit/miss ignored
    for (int i = 0; i < 10; i++) begin
      hit  = (i == 3);
      miss = (i == 5);
      expect_state("idle", FlNewGame, 'h00, 3);
      check("idle.ts", timer_start, 0);
      tick();
    end
    hit  = 1'b0;
    miss = 1'b0;

    // 2: start, BCD carry, saturation
    btn = 2'b01;
    tick();
    btn = 2'b00;
    expect_state("start", FlPlay, 'h00, 2);
    hits(12);
    expect_state("hits12", FlPlay, 'h12, 2);
    hits(88);
    expect_state("hits100", FlPlay, 'h99, 2);
    hits(3);
    expect_state("sat", FlPlay, 'h99, 2);

    // 3: miss -> NEWBALL; buttons ignored until timer expires
    do_miss("miss1");
    expect_state("nb1", FlNewBall, 'h99, 1);
    btn = 2'b10;
    tick();
    tick();
    expect_state("nb_hold", FlNewBall, 'h99, 1);
    check("nb_hold.ts", timer_start, 0);
    btn      = 2'b00;
    timer_up = 1'b1;
    tick();
    expect_state("nb_nobtn", FlNewBall, 'h99, 1);
    btn = 2'b10;
    tick();
    btn      = 2'b00;
    timer_up = 1'b0;
    expect_state("replay1", FlPlay, 'h99, 1);

    // 4: run out of balls -> OVER -> NEWGAME
    do_miss("miss2");
    expect_state("nb2", FlNewBall, 'h99, 0);
    relaunch();
    expect_state("replay2", FlPlay, 'h99, 0);
    do_miss("miss3");
    expect_state("over", FlOver, 'h99, 0);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    expect_state("over_hold", FlOver, 'h99, 0);
    timer_up = 1'b1;
    #1;
    check("over_exit.ts", timer_start, 0);
    tick();
    timer_up = 1'b0;
    expect_state("regame", FlNewGame, 'h00, 3);

    // 5: hit and miss together
    btn = 2'b11;
    tick();
    btn = 2'b00;
    hits(5);
    do_miss("m5a");
    relaunch();
    expect_state("pre_hm", FlPlay, 'h05, 1);
    hit = 1'b1;
    do_miss("hitmiss");
    hit = 1'b0;
    expect_state("hitmiss", FlNewBall, 'h06, 0);

    // 6: reset mid-game from NEWBALL with score 37
    do_reset();
    btn = 2'b01;
    tick();
    btn = 2'b00;
    hits(37);
    do_miss("m37");
    expect_state("nb37", FlNewBall, 'h37, 1);
    do_reset();
    expect_state("rst_nb", FlNewGame, 'h00, 3);

    // reset while a miss arrives in PLAY: no timer pulse
    btn = 2'b01;
    tick();
    btn   = 2'b00;
    hits(2);
    reset = 1'b1;
    miss  = 1'b1;
    #1;
    check("rst_miss.ts", timer_start, 0);
    tick();
    reset = 1'b0;
    miss  = 1'b0;
    expect_state("rst_play", FlNewGame, 'h00, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for Pong. It owns the play/pause state machine, the 2-digit BCD score and the remaining-ball count, and drives the countdown timer via timer_start. It consumes hit/miss pulses from the graphics/ball logic and button levels from the debounced paddle keys. Its outputs gate ball motion (gra_still) and select the text overlays (rule screen, game-over screen).

Parameters:
BALLS, 3, balls in reserve at game start (a further ball is put in play on start); must be < 2**BALL_W
BALL_W, 2, width of balls_left

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn  input  2  debounced paddle buttons, level; "pressed" means btn != 0
hit  input  1  1-cycle pulse: ball bounced off paddle
miss  input  1  1-cycle pulse: ball passed paddle
timer_up  input  1  countdown timer expired (level, from timer block)
timer_start  output  1  reload countdown timer; combinational (Mealy) pulse
gra_still  output  1  1 = freeze ball/paddle motion
show_rule  output  1  1 = display rule/start text
show_over  output  1  1 = display game-over text
score_d1  output  4  score tens digit, BCD
score_d0  output  4  score units digit, BCD
balls_left  output  BALL_W  balls remaining in reserve

Behaviour:
- One clock. Reset is synchronous and active-high. Registers update only on posedge clk.
- Reset: state=NEWGAME, score_d1=0, score_d0=0, balls_left=BALLS. Decoded outputs: gra_still=1, show_rule=1, show_over=0, timer_start=0.
- States: NEWGAME, PLAY, NEWBALL, OVER. Use a 2-bit encoding. An illegal encoding returns to NEWGAME on the next edge.
- Decoded outputs:
  - NEWGAME: gra_still=1, show_rule=1.
  - PLAY: gra_still=0.
  - NEWBALL: gra_still=1.
  - OVER: gra_still=1, show_over=1.
  - All other overlay flags are 0.
- NEWGAME:
  - btn!=0 -> PLAY; balls_left <= BALLS-1.
  - Otherwise hold.
- PLAY:
  - hit=1 -> score += 1 in BCD. Units 9 carries to tens. Saturates at 99, with no wrap.
  - miss=1 and balls_left!=0 -> NEWBALL; balls_left <= balls_left-1; timer_start=1 in this same cycle.
  - miss=1 and balls_left==0 -> OVER; timer_start=1 in this same cycle.
  - hit and miss in the same cycle: both take effect (score increments and the miss transition occurs).
- NEWBALL:
  - timer_up=1 and btn!=0 -> PLAY.
  - Otherwise hold. Buttons are ignored until the timer expires.
- OVER:
  - timer_up=1 -> NEWGAME; score cleared to 00 and balls_left <= BALLS on that edge.
  - Score holds its final value throughout OVER.
- hit/miss outside PLAY are ignored.
- timer_start must be combinational, asserted only in the transition cycle. The timer then reloads on the same edge the state changes, so timer_up is 0 in the first cycle of NEWBALL/OVER, even if the timer previously sat at 0.
- timer_start is never asserted in NEWGAME or in steady-state cycles.
- Reset mid-game (any state): returns to NEWGAME with score 00 and balls_left=BALLS on the next edge. timer_start=0 during reset.
- All counters are registered. There are no latches; combinational next-state logic has defaults for every output.

Test Plan:
1. Reset; btn=0 for 10 cycles -> state NEWGAME, show_rule=1, gra_still=1, score 00, balls_left=3, timer_start=0 throughout.
2. btn=01 in NEWGAME -> next cycle PLAY, gra_still=0, balls_left=2. Then 12 hit pulses -> score_d1=1, score_d0=2. Then 100 total hits -> score stays 99.
3. In PLAY with balls_left=2, pulse miss -> timer_start=1 in the miss cycle only, then NEWBALL, balls_left=1. Hold btn=10 with timer_up=0 -> stays NEWBALL. Raise timer_up -> PLAY next cycle.
4. Three misses from game start (each followed by timer_up+btn) -> third miss with balls_left=0 gives OVER, show_over=1, timer_start pulse. Score retained. timer_up -> NEWGAME, score 00, balls_left=3.
5. hit and miss asserted in the same PLAY cycle with score 05, balls_left=1 -> score 06, NEWBALL, balls_left=0, timer_start=1.
6. Assert reset for 1 cycle while in NEWBALL with score 37 -> next cycle NEWGAME, score 00, balls_left=3, show_rule=1.
